pll_lock_reset_seq: RTL and testbench

- Consumes the PLL `locked` indication and drives the PLL reset input.
- Produces sequenced, lock-qualified active-low resets for the 10G Ethernet core and MAC domains.
- Runs on the free-running board reference clock, because the PLL outputs are invalid before lock.
- Retries the PLL on lock timeout and counts loss-of-lock events.

---
 rtl/pll_lock_reset_pkg.sv | 28 ++
 rtl/pll_lock_sync.sv | 20 ++
 rtl/pll_lock_reset_seq.sv | 160 ++++++++++++++++
 tb/tb_pll_lock_reset_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_reset_pkg.sv
// Shared types and helpers for the PLL lock / reset sequencer.
package pll_lock_reset_pkg;

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_REL_CORE,
    S_RUN
  } state_e;

  // Timer must hold N-1 for the longest timed state.
  function automatic int tmr_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Multi-flop single-bit synchronizer with asynchronous active-low clear to 0.
module pll_lock_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_reset_seq.sv
// PLL lock supervisor: drives PLL reset, releases core then MAC resets after stable lock.
// Optional debug outputs (retry counter, timeout sticky) enabled by PLL_LOCK_DEBUG_EN.
module pll_lock_reset_seq
  import pll_lock_reset_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 1000000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int STAGE_GAP      = 16,
  parameter int CNT_W          = 8
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             pll_locked_i,
  input  logic             sw_reset_i,
  output logic             pll_rst_o,
  output logic             rst_core_n_o,
  output logic             rst_mac_n_o,
  output logic             lock_ok_o,
  output logic [CNT_W-1:0] lock_loss_cnt_o
`ifdef PLL_LOCK_DEBUG_EN
  ,
  output logic [CNT_W-1:0] pll_retry_cnt_o,
  output logic             timeout_sticky_o
`endif
);

  localparam int TMR_W = tmr_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, STAGE_GAP);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             started_q;
  logic             pll_rst_q, core_q, mac_q, ok_q;
  logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;
  logic             lk, loss, tmo;

  pll_lock_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d_i   (pll_locked_i),
    .q_o   (lk)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TMR_W'(1);
    loss    = 1'b0;
    tmo     = 1'b0;
    // The first edge after reset release counts as entry into S_PLL_RST.
    if (!started_q) begin
      state_d = S_PLL_RST;
      timer_d = '0;
    end else if (sw_reset_i) begin
      state_d = S_PLL_RST;
      timer_d = '0;
    end else begin
      case (state_q)
        S_PLL_RST: begin
          if (timer_q == TMR_W'(PLL_RST_CYCLES - 1)) begin
            state_d = S_WAIT_LOCK;
            timer_d = '0;
          end
        end
        S_WAIT_LOCK: begin
          if (lk) begin
            state_d = S_STABLE;
            timer_d = '0;
          end else if (timer_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
            state_d = S_PLL_RST;
            timer_d = '0;
            tmo     = 1'b1;
          end
        end
        S_STABLE: begin
          if (!lk) begin
            state_d = S_WAIT_LOCK;
            timer_d = '0;
          end else if (timer_q == TMR_W'(STABLE_CYCLES - 1)) begin
            state_d = S_REL_CORE;
            timer_d = '0;
          end
        end
        S_REL_CORE: begin
          if (!lk) begin
            state_d = S_WAIT_LOCK;
            timer_d = '0;
            loss    = 1'b1;
          end else if (timer_q == TMR_W'(STAGE_GAP - 1)) begin
            state_d = S_RUN;
            timer_d = '0;
          end
        end
        S_RUN: begin
          timer_d = '0;
          if (!lk) begin
            state_d = S_WAIT_LOCK;
            loss    = 1'b1;
          end
        end
        default: begin
          state_d = S_PLL_RST;
          timer_d = '0;
        end
      endcase
    end
    loss_cnt_d = loss ? CNT_W'(sat_inc(32'(loss_cnt_q), CNT_W)) : loss_cnt_q;
  end

  // Outputs are decoded from the next state so they move on the same edge.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_PLL_RST;
      timer_q    <= '0;
      started_q  <= 1'b0;
      pll_rst_q  <= 1'b1;
      core_q     <= 1'b0;
      mac_q      <= 1'b0;
      ok_q       <= 1'b0;
      loss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      started_q  <= 1'b1;
      pll_rst_q  <= (state_d == S_PLL_RST);
      core_q     <= (state_d == S_REL_CORE) || (state_d == S_RUN);
      mac_q      <= (state_d == S_RUN);
      ok_q       <= (state_d == S_RUN);
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign pll_rst_o       = pll_rst_q;
  assign rst_core_n_o    = core_q;
  assign rst_mac_n_o     = mac_q;
  assign lock_ok_o       = ok_q;
  assign lock_loss_cnt_o = loss_cnt_q;

`ifdef PLL_LOCK_DEBUG_EN
  logic [CNT_W-1:0] retry_cnt_q;
  logic             sticky_q;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt_q <= '0;
      sticky_q    <= 1'b0;
    end else if (tmo) begin
      retry_cnt_q <= CNT_W'(sat_inc(32'(retry_cnt_q), CNT_W));
      sticky_q    <= 1'b1;
    end
  end

  assign pll_retry_cnt_o  = retry_cnt_q;
  assign timeout_sticky_o = sticky_q;
`else
  logic unused_tmo;
  assign unused_tmo = tmo;
`endif

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Scoreboard bench: stimulus queues expected output changes, a monitor checks each change.
module tb_pll_lock_reset_seq;

  localparam int CW = 8;

  logic          refclk = 1'b0;
  logic          rst_n  = 1'b0;
  logic          pll_locked_i = 1'b0;
  logic          sw_reset_i   = 1'b0;
  logic          pll_rst_o, rst_core_n_o, rst_mac_n_o, lock_ok_o;
  logic [CW-1:0] lock_loss_cnt_o;
  logic [20:0]   obs;
`ifdef PLL_LOCK_DEBUG_EN
  logic [CW-1:0] pll_retry_cnt_o;
  logic          timeout_sticky_o;
`endif

  pll_lock_reset_seq #(
    .SYNC_STAGES(2), .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(20),
    .STABLE_CYCLES(8), .STAGE_GAP(3), .CNT_W(CW)
  ) dut (
    .refclk          (refclk),
    .rst_n           (rst_n),
    .pll_locked_i    (pll_locked_i),
    .sw_reset_i      (sw_reset_i),
    .pll_rst_o       (pll_rst_o),
    .rst_core_n_o    (rst_core_n_o),
    .rst_mac_n_o     (rst_mac_n_o),
    .lock_ok_o       (lock_ok_o),
    .lock_loss_cnt_o (lock_loss_cnt_o)
`ifdef PLL_LOCK_DEBUG_EN
    ,
    .pll_retry_cnt_o (pll_retry_cnt_o),
    .timeout_sticky_o(timeout_sticky_o)
`endif
  );

`ifdef PLL_LOCK_DEBUG_EN
  assign obs = {pll_rst_o, rst_core_n_o, rst_mac_n_o, lock_ok_o, lock_loss_cnt_o,
                pll_retry_cnt_o, timeout_sticky_o};
`else
  assign obs = {pll_rst_o, rst_core_n_o, rst_mac_n_o, lock_ok_o, lock_loss_cnt_o, 9'd0};
`endif

  always #5 refclk = ~refclk;

  int cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [20:0] v;
    string       name;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   done  = 1'b0;

  function automatic logic [20:0] mk(input bit pr, input bit c, input bit m, input bit ok,
                                     input int cnt, input int rc, input bit st);
    int rcx;
    bit stx;
    rcx = rc;
    stx = st;
`ifndef PLL_LOCK_DEBUG_EN
    rcx = 0;
    stx = 1'b0;
`endif
    return {pr, c, m, ok, 8'(cnt), 8'(rcx), stx};
  endfunction

  task automatic push(input int c, input logic [20:0] v, input string n);
    exp_t e;
    e.cyc  = c;
    e.v    = v;
    e.name = n;
    q.push_back(e);
  endtask

  // Return 2 time units after the posedge that makes cyc == c.
  task automatic at(input int c);
    repeat (c - cyc) @(posedge refclk);
    #2;
  endtask

  initial begin
    push(1, mk(1, 0, 0, 0, 0, 0, 0), "reset_state");

    // Power-up; lock arrives 10 cycles after release
    push(7,  mk(0, 0, 0, 0, 0, 0, 0), "pll_rst_4cyc");
    push(23, mk(0, 1, 0, 0, 0, 0, 0), "core_release");
    push(26, mk(0, 1, 1, 1, 0, 0, 0), "mac_release");
    at(2);  rst_n = 1'b1;
    at(12); pll_locked_i = 1'b1;

    // Lock drop in S_RUN, then relock
    push(33, mk(0, 0, 0, 0, 1, 0, 0), "run_loss");
    push(47, mk(0, 1, 0, 0, 1, 0, 0), "relock_core");
    push(50, mk(0, 1, 1, 1, 1, 0, 0), "relock_mac");
    at(30); pll_locked_i = 1'b0;
    at(36); pll_locked_i = 1'b1;

    // One-cycle glitch at S_STABLE timer 5 restarts the stable window
    push(58, mk(0, 0, 0, 0, 2, 0, 0), "run_loss2");
    push(78, mk(0, 1, 0, 0, 2, 0, 0), "glitch_core");
    push(81, mk(0, 1, 1, 1, 2, 0, 0), "glitch_mac");
    at(55); pll_locked_i = 1'b0;
    at(60); pll_locked_i = 1'b1;
    at(66); pll_locked_i = 1'b0;
    at(67); pll_locked_i = 1'b1;

    // sw_reset in the same cycle lk falls: no loss counted
    push(87, mk(1, 0, 0, 0, 2, 0, 0), "swrst_priority");
    push(91, mk(0, 0, 0, 0, 2, 0, 0), "swrst_pll_done");
    at(84); pll_locked_i = 1'b0;
    at(86); sw_reset_i = 1'b1;
    at(87); sw_reset_i = 1'b0;

    // Lock held low: retry every 24 cycles
    push(111, mk(1, 0, 0, 0, 2, 1, 1), "timeout1");
    push(115, mk(0, 0, 0, 0, 2, 1, 1), "retry1_end");
    push(135, mk(1, 0, 0, 0, 2, 2, 1), "timeout2");
    push(139, mk(0, 0, 0, 0, 2, 2, 1), "retry2_end");
    push(159, mk(1, 0, 0, 0, 2, 3, 1), "timeout3");
    push(163, mk(0, 0, 0, 0, 2, 3, 1), "retry3_end");

    // Asynchronous reset in the middle of S_STABLE
    push(171, mk(1, 0, 0, 0, 0, 0, 0), "async_reset");
    at(165); pll_locked_i = 1'b1;
    at(171); rst_n = 1'b0; pll_locked_i = 1'b0;
    push(178, mk(0, 0, 0, 0, 0, 0, 0), "restart_pll_done");
    at(173); rst_n = 1'b1;

    // 256 losses from S_REL_CORE: counter saturates at 255
    for (int i = 0; i < 256; i++) begin
      int c;
      c = 180 + 14 * i;
      push(c + 11, mk(0, 1, 0, 0, (i > 255) ? 255 : i, 0, 0), "sat_core");
      push(c + 13, mk(0, 0, 0, 0, (i + 1 > 255) ? 255 : i + 1, 0, 0), "sat_loss");
      at(c);      pll_locked_i = 1'b1;
      at(c + 10); pll_locked_i = 1'b0;
    end
    at(3780);
    done = 1'b1;
  end

  initial begin
    logic [20:0] prev;
    exp_t        e;
    prev = 'x;
    forever begin
      @(negedge refclk or negedge rst_n);
      #1;
      if (obs !== prev) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_change: got %h at cycle %0d, required no change", obs, cyc);
        end else begin
          e = q.pop_front();
          if (obs !== e.v || cyc != e.cyc) begin
            fails++;
            $display("FAIL %s: got %h at cycle %0d, required %h at cycle %0d",
                     e.name, obs, cyc, e.v, e.cyc);
          end
        end
        prev = obs;
      end
      if (done) break;
      if (cyc > 6000) begin
        tests++;
        fails++;
        $display("FAIL watchdog: got cycle %0d, required completion by 6000", cyc);
        break;
      end
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL pending_events: got %0d unseen, required 0 (next %s at cycle %0d)",
               q.size(), q[0].name, q[0].cyc);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
